// File: rtl/ecc_75_rd_err_mon.sv
// ECC read-path error monitor: 2-entry skid buffer, saturating error counters, first-error capture, irq.
// Build option: define ECC_DBIT_DROP_EN to drop double-bit beats from the data path (out_poison tied 0).
module ecc_75_rd_err_mon #(
    parameter int unsigned DATA_WIDTH = 75,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned SBIT_THR   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_vld,
    output logic                  in_rdy,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  in_sbit_err,
    input  logic                  in_dbit_err,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_poison,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic                  err_vld,
    output logic                  err_type,
    output logic [ADDR_WIDTH-1:0] err_addr,
    input  logic                  irq_en,
    input  logic                  clr,
    output logic                  irq
);

`ifdef ECC_DBIT_DROP_EN
    localparam bit DROP_DBIT = 1'b1;
`else
    localparam bit DROP_DBIT = 1'b0;
`endif

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                  acc, push, pop, err_s, err_d, in_poison;
    logic                  skid_vld, skid_poison;
    logic [DATA_WIDTH-1:0] skid_data;

    logic                  out_vld_nx, out_poison_nx, skid_vld_nx, skid_poison_nx, in_rdy_nx;
    logic [DATA_WIDTH-1:0] out_data_nx, skid_data_nx;
    logic [CNT_WIDTH-1:0]  sbit_nx, dbit_nx;
    logic                  err_vld_nx, err_type_nx, irq_nx;
    logic [ADDR_WIDTH-1:0] err_addr_nx;

    // Next-state: head register (out_*) backed by one skid entry; counters and capture.
    always_comb begin
        out_vld_nx     = out_vld;
        out_data_nx    = out_data;
        out_poison_nx  = out_poison;
        skid_vld_nx    = skid_vld;
        skid_data_nx   = skid_data;
        skid_poison_nx = skid_poison;

        acc       = in_vld & in_rdy;
        err_d     = acc & in_dbit_err;
        err_s     = acc & in_sbit_err & ~in_dbit_err;
        push      = acc & ~(DROP_DBIT & in_dbit_err);
        pop       = out_vld & out_rdy;
        in_poison = in_dbit_err & ~DROP_DBIT;

        if (pop) begin
            if (skid_vld) begin
                out_data_nx   = skid_data;
                out_poison_nx = skid_poison;
                skid_vld_nx   = push;
                if (push) begin
                    skid_data_nx   = in_data;
                    skid_poison_nx = in_poison;
                end
            end else begin
                out_vld_nx = push;
                if (push) begin
                    out_data_nx   = in_data;
                    out_poison_nx = in_poison;
                end
            end
        end else if (push) begin
            if (!out_vld) begin
                out_vld_nx    = 1'b1;
                out_data_nx   = in_data;
                out_poison_nx = in_poison;
            end else begin
                skid_vld_nx    = 1'b1;
                skid_data_nx   = in_data;
                skid_poison_nx = in_poison;
            end
        end
        in_rdy_nx = ~(out_vld_nx & skid_vld_nx);

        // clr takes effect before the same-cycle beat is counted/captured.
        sbit_nx     = clr ? '0 : sbit_cnt;
        dbit_nx     = clr ? '0 : dbit_cnt;
        err_vld_nx  = clr ? 1'b0 : err_vld;
        err_type_nx = clr ? 1'b0 : err_type;
        err_addr_nx = clr ? '0 : err_addr;

        if (err_s && sbit_nx != CNT_MAX) sbit_nx = sbit_nx + CNT_WIDTH'(1);
        if (err_d && dbit_nx != CNT_MAX) dbit_nx = dbit_nx + CNT_WIDTH'(1);

        if (err_s || err_d) begin
            if (!err_vld_nx || (!err_type_nx && err_d)) begin
                err_vld_nx  = 1'b1;
                err_type_nx = err_d;
                err_addr_nx = in_addr;
            end
        end

        irq_nx = irq_en & ((32'(sbit_nx) >= SBIT_THR) | (dbit_nx != '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld     <= 1'b0;
            out_data    <= '0;
            out_poison  <= 1'b0;
            skid_vld    <= 1'b0;
            skid_data   <= '0;
            skid_poison <= 1'b0;
            in_rdy      <= 1'b1;
            sbit_cnt    <= '0;
            dbit_cnt    <= '0;
            err_vld     <= 1'b0;
            err_type    <= 1'b0;
            err_addr    <= '0;
            irq         <= 1'b0;
        end else begin
            out_vld     <= out_vld_nx;
            out_data    <= out_data_nx;
            out_poison  <= out_poison_nx;
            skid_vld    <= skid_vld_nx;
            skid_data   <= skid_data_nx;
            skid_poison <= skid_poison_nx;
            in_rdy      <= in_rdy_nx;
            sbit_cnt    <= sbit_nx;
            dbit_cnt    <= dbit_nx;
            err_vld     <= err_vld_nx;
            err_type    <= err_type_nx;
            err_addr    <= err_addr_nx;
            irq         <= irq_nx;
        end
    end

endmodule

// File: tb/tb_ecc_75_rd_err_mon.sv
// Bench for ecc_75_rd_err_mon: scoreboarded data path, vector table for counters/capture/irq, corner sequences.
module tb_ecc_75_rd_err_mon;
    localparam int unsigned DW = 75;
    localparam int unsigned AW = 8;
    localparam int unsigned CW = 16;
`ifdef ECC_DBIT_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, in_vld, in_sbit_err, in_dbit_err, out_rdy, irq_en, clr;
    logic [DW-1:0] in_data;
    logic [AW-1:0] in_addr;
    logic          in_rdy, out_vld, out_poison, err_vld, err_type, irq;
    logic [DW-1:0] out_data;
    logic [CW-1:0] sbit_cnt, dbit_cnt;
    logic [AW-1:0] err_addr;
    // Narrow-counter instance sharing all inputs, for saturation.
    logic          s_in_rdy, s_out_vld, s_out_poison, s_err_vld, s_err_type, s_irq;
    logic [DW-1:0] s_out_data;
    logic [3:0]    s_sbit_cnt, s_dbit_cnt;
    logic [AW-1:0] s_err_addr;

    always #5 clk = ~clk;

    ecc_75_rd_err_mon dut (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .in_addr(in_addr), .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_poison(out_poison),
        .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .err_vld(err_vld), .err_type(err_type),
        .err_addr(err_addr), .irq_en(irq_en), .clr(clr), .irq(irq)
    );

    ecc_75_rd_err_mon #(.CNT_WIDTH(4)) u_sat (
        .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(s_in_rdy), .in_data(in_data),
        .in_addr(in_addr), .in_sbit_err(in_sbit_err), .in_dbit_err(in_dbit_err),
        .out_vld(s_out_vld), .out_rdy(out_rdy), .out_data(s_out_data), .out_poison(s_out_poison),
        .sbit_cnt(s_sbit_cnt), .dbit_cnt(s_dbit_cnt), .err_vld(s_err_vld), .err_type(s_err_type),
        .err_addr(s_err_addr), .irq_en(irq_en), .clr(clr), .irq(s_irq)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic          poison;
    } beat_t;

    typedef struct {
        logic          vld, sbit, dbit, clr, en;
        logic [AW-1:0] addr;
        logic [CW-1:0] e_s, e_d;
        logic          e_ev, e_et;
        logic [AW-1:0] e_ea;
        logic          e_irq;
    } vec_t;

    beat_t sb[$];
    beat_t exp_b;
    vec_t  tbl[28];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Consumer-side scoreboard: every delivered beat must match the oldest accepted one.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got data %0h with empty scoreboard", out_data);
            end else begin
                exp_b = sb.pop_front();
                chk("out_data", 80'(out_data), 80'(exp_b.data));
                chk("out_poison", 80'(out_poison), 80'(exp_b.poison));
            end
        end
    end

    function automatic logic [DW-1:0] rd();
        return DW'({$urandom, $urandom, $urandom});
    endfunction

    function automatic vec_t mk(input logic vld, sbit, dbit, c, en, input logic [AW-1:0] addr,
                                input int s, d, input logic ev, et, input logic [AW-1:0] ea,
                                input logic iq);
        vec_t v;
        v.vld = vld; v.sbit = sbit; v.dbit = dbit; v.clr = c; v.en = en; v.addr = addr;
        v.e_s = CW'(s); v.e_d = CW'(d); v.e_ev = ev; v.e_et = et; v.e_ea = ea; v.e_irq = iq;
        return v;
    endfunction

    task automatic step();
        if (!rst && in_vld && in_rdy && !(DROP && in_dbit_err))
            sb.push_back({in_data, in_dbit_err & ~DROP});
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input logic [AW-1:0] a, input logic s, input logic db);
        logic took;
        took = 1'b0;
        in_vld = 1'b1; in_data = d; in_addr = a; in_sbit_err = s; in_dbit_err = db;
        for (int i = 0; i < 50; i++) begin
            took = in_rdy;
            step();
            if (took) break;
        end
        if (!took) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: beat at addr %0h never accepted", a);
        end
        in_vld = 1'b0; in_sbit_err = 1'b0; in_dbit_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_vld = 1'b0; clr = 1'b0;
        step();
        sb.delete();
        chk("rst_out_vld", 80'(out_vld), 80'(0));
        chk("rst_in_rdy", 80'(in_rdy), 80'(1));
        chk("rst_out_data", 80'(out_data), 80'(0));
        chk("rst_out_poison", 80'(out_poison), 80'(0));
        chk("rst_sbit_cnt", 80'(sbit_cnt), 80'(0));
        chk("rst_dbit_cnt", 80'(dbit_cnt), 80'(0));
        chk("rst_err_vld", 80'(err_vld), 80'(0));
        chk("rst_err_type", 80'(err_type), 80'(0));
        chk("rst_err_addr", 80'(err_addr), 80'(0));
        chk("rst_irq", 80'(irq), 80'(0));
        chk("rst_sat_sbit", 80'(s_sbit_cnt), 80'(0));
        chk("rst_sat_out_vld", 80'(s_out_vld), 80'(0));
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() != 0; i++) step();
        chk("drain_empty", 80'(sb.size()), 80'(0));
    endtask

    logic [DW-1:0] b0, b1, b2, d;

    initial begin
        rst = 1'b1; in_vld = 1'b0; in_sbit_err = 1'b0; in_dbit_err = 1'b0;
        in_data = '0; in_addr = '0; out_rdy = 1'b1; irq_en = 1'b0; clr = 1'b0;

        // 16 sbit beats, clr corner cases, dbit upgrade/freeze, irq_en gating
        for (int i = 0; i < 16; i++)
            tbl[i] = mk(1, 1, 0, 0, 1, AW'(8'h20 + i), i + 1, 0, 1, 0, 8'h20, (i + 1) >= 16);
        tbl[16] = mk(0, 0, 0, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        tbl[17] = mk(1, 1, 0, 0, 1, 8'h05, 1, 0, 1, 0, 8'h05, 0);
        tbl[18] = mk(1, 0, 1, 0, 1, 8'h09, 1, 1, 1, 1, 8'h09, 1);
        tbl[19] = mk(1, 0, 1, 0, 1, 8'h0c, 1, 2, 1, 1, 8'h09, 1);
        tbl[20] = mk(1, 1, 1, 0, 1, 8'h03, 1, 3, 1, 1, 8'h09, 1);
        tbl[21] = mk(0, 0, 0, 0, 0, 8'h00, 1, 3, 1, 1, 8'h09, 0);
        tbl[22] = mk(0, 0, 0, 0, 1, 8'h00, 1, 3, 1, 1, 8'h09, 1);
        tbl[23] = mk(1, 1, 0, 1, 1, 8'h07, 1, 0, 1, 0, 8'h07, 0);
        tbl[24] = mk(1, 0, 1, 1, 1, 8'h44, 0, 1, 1, 1, 8'h44, 1);
        tbl[25] = mk(1, 1, 0, 0, 1, 8'h50, 1, 1, 1, 1, 8'h44, 1);
        tbl[26] = mk(0, 0, 0, 1, 1, 8'h00, 0, 0, 0, 0, 8'h00, 0);
        tbl[27] = mk(1, 0, 1, 0, 1, 8'h60, 0, 1, 1, 1, 8'h60, 1);

        do_reset();

        // Clean beats, 1-cycle latency
        for (int i = 0; i < 4; i++) begin
            d = rd();
            send(d, AW'(i), 1'b0, 1'b0);
            if (i == 0) begin
                chk("lat_out_vld", 80'(out_vld), 80'(1));
                chk("lat_out_data", 80'(out_data), 80'(d));
            end
        end
        drain();
        chk("clean_sbit_cnt", 80'(sbit_cnt), 80'(0));
        chk("clean_dbit_cnt", 80'(dbit_cnt), 80'(0));
        chk("clean_irq", 80'(irq), 80'(0));
        chk("clean_err_vld", 80'(err_vld), 80'(0));

        // Back-pressure: two accepts fill the buffer, third held off
        out_rdy = 1'b0;
        b0 = rd(); b1 = rd(); b2 = rd();
        send(b0, 8'h10, 1'b0, 1'b0);
        chk("bp_rdy_after1", 80'(in_rdy), 80'(1));
        send(b1, 8'h11, 1'b0, 1'b0);
        chk("bp_rdy_full", 80'(in_rdy), 80'(0));
        in_vld = 1'b1; in_data = b2; in_addr = 8'h12;
        step();
        step();
        chk("bp_rdy_held", 80'(in_rdy), 80'(0));
        chk("bp_out_vld", 80'(out_vld), 80'(1));
        chk("bp_hold_data", 80'(out_data), 80'(b0));
        out_rdy = 1'b1;
        send(b2, 8'h12, 1'b0, 1'b0);
        drain();

        // Vector table, one cycle per record
        for (int i = 0; i < 28; i++) begin
            in_vld = tbl[i].vld; in_sbit_err = tbl[i].sbit; in_dbit_err = tbl[i].dbit;
            in_addr = tbl[i].addr; clr = tbl[i].clr; irq_en = tbl[i].en; in_data = rd();
            step();
            chk($sformatf("v%0d_sbit_cnt", i), 80'(sbit_cnt), 80'(tbl[i].e_s));
            chk($sformatf("v%0d_dbit_cnt", i), 80'(dbit_cnt), 80'(tbl[i].e_d));
            chk($sformatf("v%0d_err_vld", i), 80'(err_vld), 80'(tbl[i].e_ev));
            chk($sformatf("v%0d_err_type", i), 80'(err_type), 80'(tbl[i].e_et));
            chk($sformatf("v%0d_err_addr", i), 80'(err_addr), 80'(tbl[i].e_ea));
            chk($sformatf("v%0d_irq", i), 80'(irq), 80'(tbl[i].e_irq));
        end
        in_vld = 1'b0; in_sbit_err = 1'b0; in_dbit_err = 1'b0; clr = 1'b0; irq_en = 1'b0;
        drain();

        // Saturation on the 4-bit instance, then reset with a full buffer
        do_reset();
        for (int n = 1; n <= 20; n++) begin
            send(rd(), AW'(n), 1'b1, 1'b0);
            chk($sformatf("sat_wide_%0d", n), 80'(sbit_cnt), 80'(n));
            chk($sformatf("sat_narrow_%0d", n), 80'(s_sbit_cnt), 80'(n > 15 ? 15 : n));
        end
        out_rdy = 1'b0;
        send(rd(), 8'h70, 1'b1, 1'b0);
        chk("pre_rst_out_vld", 80'(out_vld), 80'(1));
        chk("pre_rst_full", 80'(in_rdy), 80'(0));
        in_vld = 1'b1; in_data = rd(); in_sbit_err = 1'b1;
        do_reset();
        in_vld = 1'b0; in_sbit_err = 1'b0; out_rdy = 1'b1;
        step();
        chk("post_rst_out_vld", 80'(out_vld), 80'(0));
        chk("post_rst_sbit", 80'(sbit_cnt), 80'(0));
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
